yuv_csc_upsampler: RTL and testbench

Parametrised colour-space conversion engine for the image decompressor datapath. It reads planar Y/U/V data from the shared 16-bit single-port SRAM and optionally upsamples chroma horizontally from 4:2:2 to 4:4:4 with a 6-tap FIR. It converts each pixel to 8-bit RGB and writes packed RGB words back to SRAM. It is the next generation of the fixed-size upsample/CSC stage: frame geometry and plane bases are parameters, and chroma mode is selectable per frame.

---
 rtl/yuv_csc_upsampler.sv | 266 ++++++++++++++++++++++++++
 tb/tb_yuv_csc_upsampler.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/yuv_csc_upsampler.sv
// Planar YUV (4:2:2 or 4:4:4) to packed 8-bit RGB, SRAM to SRAM.
// One pixel pair per 8-cycle slot: 3 reads of the next pair's data, then 3 writes of this pair.
module yuv_csc_upsampler #(
    parameter int WIDTH    = 320,
    parameter int HEIGHT   = 240,
    parameter int Y_BASE   = 0,
    parameter int U_BASE   = 38400,
    parameter int V_BASE   = 57600,
    parameter int RGB_BASE = 146944
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        start,
    input  logic        mode_444,
    output logic        busy,
    output logic        done,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    input  logic [15:0] SRAM_read_data
);

    typedef enum logic [2:0] {S_IDLE, S_LEAD_IN, S_COMMON, S_LEAD_OUT, S_DONE} state_t;

    localparam logic [15:0] LP_H      = 16'(WIDTH / 2);
    localparam logic [15:0] LP_ROWS   = 16'(HEIGHT);
    localparam logic [17:0] LP_YB     = 18'(Y_BASE);
    localparam logic [17:0] LP_UB     = 18'(U_BASE);
    localparam logic [17:0] LP_VB     = 18'(V_BASE);
    localparam logic [17:0] LP_RB     = 18'(RGB_BASE);
    localparam logic [17:0] LP_YS     = 18'(WIDTH / 2);
    localparam logic [17:0] LP_CS422  = 18'(WIDTH / 4);
    localparam logic [17:0] LP_CS444  = 18'(WIDTH / 2);

    state_t      r_state;
    logic [2:0]  r_cyc;
    logic [15:0] r_pair, r_row;
    logic        r_mode;
    logic [17:0] r_ybase, r_cbase, r_waddr, r_addr;
    logic [15:0] r_wdata, r_y, r_yc, r_u_word, r_v_word;
    logic        r_we_n, r_busy, r_done;
    logic [7:0]  r_uw [0:5];
    logic [7:0]  r_vw [0:5];
    logic [7:0]  r_ue, r_uo, r_ve, r_vo;
    logic [23:0] r_rgb0, r_rgb1;

    logic        w_fetch_y, w_fetch_c;
    logic [17:0] w_cidx;
    logic [7:0]  w_u_push, w_v_push;

    function automatic logic [7:0] clip8(input logic signed [31:0] x);
        if (x < 0)
            return 8'd0;
        else if (x > 32'sd255)
            return 8'd255;
        else
            return x[7:0];
    endfunction

    function automatic logic [7:0] fir6(input logic [7:0] a, b, c, d, e, f);
        logic signed [31:0] acc;
        acc = 32'sd21  * ($signed({24'd0, a}) + $signed({24'd0, f}))
            - 32'sd52  * ($signed({24'd0, b}) + $signed({24'd0, e}))
            + 32'sd159 * ($signed({24'd0, c}) + $signed({24'd0, d}))
            + 32'sd128;
        return clip8(acc >>> 8);
    endfunction

    function automatic logic [23:0] csc(input logic [7:0] yy, uu, vv);
        logic signed [31:0] y, u, v;
        y = $signed({24'd0, yy}) - 32'sd16;
        u = $signed({24'd0, uu}) - 32'sd128;
        v = $signed({24'd0, vv}) - 32'sd128;
        return {clip8((32'sd76284 * y + 32'sd104595 * v) >>> 16),
                clip8((32'sd76284 * y - 32'sd25624 * u - 32'sd53281 * v) >>> 16),
                clip8((32'sd76284 * y + 32'sd132251 * u) >>> 16)};
    endfunction

    // 4:2:2 window for pair k holds U[k-2..k+3]; each slot pushes U[k+4] (clamped),
    // taking a fresh word's high byte on even k and the held low byte on odd k.
    always_comb begin
        w_fetch_y = (r_pair + 16'd1) < LP_H;
        w_fetch_c = r_mode ? w_fetch_y : (!r_pair[0] && ((r_pair + 16'd4) < LP_H));
        w_cidx    = r_mode ? (18'(r_pair) + 18'd1) : 18'((r_pair + 16'd4) >> 1);
        w_u_push  = r_uw[5];
        w_v_push  = r_vw[5];
        if ((r_pair + 16'd4) < LP_H) begin
            w_u_push = r_pair[0] ? r_u_word[7:0] : r_u_word[15:8];
            w_v_push = r_pair[0] ? r_v_word[7:0] : r_v_word[15:8];
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state  <= S_IDLE;
            r_cyc    <= '0;
            r_pair   <= '0;
            r_row    <= '0;
            r_mode   <= 1'b0;
            r_ybase  <= '0;
            r_cbase  <= '0;
            r_waddr  <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_we_n   <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_y      <= '0;
            r_yc     <= '0;
            r_u_word <= '0;
            r_v_word <= '0;
            r_ue     <= '0;
            r_uo     <= '0;
            r_ve     <= '0;
            r_vo     <= '0;
            r_rgb0   <= '0;
            r_rgb1   <= '0;
            for (int unsigned i = 0; i < 6; i++) begin
                r_uw[i] <= '0;
                r_vw[i] <= '0;
            end
        end else begin
            r_we_n <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= S_LEAD_IN;
                        r_busy  <= 1'b1;
                        r_mode  <= mode_444;
                        r_cyc   <= '0;
                        r_pair  <= '0;
                        r_row   <= '0;
                        r_ybase <= LP_YB;
                        r_cbase <= '0;
                        r_waddr <= LP_RB;
                    end
                end
                S_LEAD_IN: begin
                    r_cyc <= r_cyc + 3'd1;
                    case (r_cyc)
                        3'd0: r_addr <= r_ybase;
                        3'd1: r_addr <= LP_UB + r_cbase;
                        3'd2: r_addr <= LP_VB + r_cbase;
                        3'd3: begin
                            r_y <= SRAM_read_data;
                            if (!r_mode) r_addr <= LP_UB + r_cbase + 18'd1;
                        end
                        3'd4: begin
                            if (!r_mode) begin
                                r_addr  <= LP_VB + r_cbase + 18'd1;
                                r_uw[0] <= SRAM_read_data[15:8];
                                r_uw[1] <= SRAM_read_data[15:8];
                            end
                            r_uw[2] <= SRAM_read_data[15:8];
                            r_uw[3] <= SRAM_read_data[7:0];
                        end
                        3'd5: begin
                            if (!r_mode) begin
                                r_vw[0] <= SRAM_read_data[15:8];
                                r_vw[1] <= SRAM_read_data[15:8];
                            end
                            r_vw[2] <= SRAM_read_data[15:8];
                            r_vw[3] <= SRAM_read_data[7:0];
                        end
                        3'd6: begin
                            r_uw[4] <= SRAM_read_data[15:8];
                            r_uw[5] <= SRAM_read_data[7:0];
                        end
                        default: begin
                            r_vw[4] <= SRAM_read_data[15:8];
                            r_vw[5] <= SRAM_read_data[7:0];
                            r_state <= S_COMMON;
                            r_pair  <= '0;
                        end
                    endcase
                end
                S_COMMON: begin
                    r_cyc <= r_cyc + 3'd1;
                    case (r_cyc)
                        3'd0: begin
                            r_yc <= r_y;
                            r_ue <= r_uw[2];
                            r_ve <= r_vw[2];
                            r_uo <= r_mode ? r_uw[3] : fir6(r_uw[0], r_uw[1], r_uw[2], r_uw[3], r_uw[4], r_uw[5]);
                            r_vo <= r_mode ? r_vw[3] : fir6(r_vw[0], r_vw[1], r_vw[2], r_vw[3], r_vw[4], r_vw[5]);
                            if (w_fetch_y) r_addr <= r_ybase + 18'(r_pair) + 18'd1;
                        end
                        3'd1: begin
                            r_rgb0 <= csc(r_yc[15:8], r_ue, r_ve);
                            r_rgb1 <= csc(r_yc[7:0], r_uo, r_vo);
                            if (w_fetch_c) r_addr <= LP_UB + r_cbase + w_cidx;
                        end
                        3'd2: if (w_fetch_c) r_addr <= LP_VB + r_cbase + w_cidx;
                        3'd3: if (w_fetch_y) r_y <= SRAM_read_data;
                        3'd4: if (w_fetch_c) r_u_word <= SRAM_read_data;
                        3'd5: begin
                            if (w_fetch_c) r_v_word <= SRAM_read_data;
                            r_addr  <= r_waddr;
                            r_wdata <= r_rgb0[23:8];
                            r_we_n  <= 1'b0;
                            r_waddr <= r_waddr + 18'd1;
                        end
                        3'd6: begin
                            if (r_mode) begin
                                if (w_fetch_c) begin
                                    r_uw[2] <= r_u_word[15:8];
                                    r_uw[3] <= r_u_word[7:0];
                                    r_vw[2] <= r_v_word[15:8];
                                    r_vw[3] <= r_v_word[7:0];
                                end
                            end else begin
                                for (int unsigned i = 0; i < 5; i++) begin
                                    r_uw[i] <= r_uw[i+1];
                                    r_vw[i] <= r_vw[i+1];
                                end
                                r_uw[5] <= w_u_push;
                                r_vw[5] <= w_v_push;
                            end
                            r_addr  <= r_waddr;
                            r_wdata <= {r_rgb0[7:0], r_rgb1[23:16]};
                            r_we_n  <= 1'b0;
                            r_waddr <= r_waddr + 18'd1;
                        end
                        default: begin
                            r_addr  <= r_waddr;
                            r_wdata <= r_rgb1[15:0];
                            r_we_n  <= 1'b0;
                            r_waddr <= r_waddr + 18'd1;
                            if (r_pair == LP_H - 16'd1)
                                r_state <= S_LEAD_OUT;
                            else
                                r_pair <= r_pair + 16'd1;
                        end
                    endcase
                end
                S_LEAD_OUT: begin
                    if (r_row == LP_ROWS - 16'd1) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= S_LEAD_IN;
                        r_row   <= r_row + 16'd1;
                        r_ybase <= r_ybase + LP_YS;
                        r_cbase <= r_cbase + (r_mode ? LP_CS444 : LP_CS422);
                        r_cyc   <= '0;
                        r_pair  <= '0;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign SRAM_address    = r_addr;
    assign SRAM_write_data = r_wdata;
    assign SRAM_we_n       = r_we_n;

endmodule

// File: tb/tb_yuv_csc_upsampler.sv
// Scoreboard bench for yuv_csc_upsampler: a pixel-level reference model queues the expected
// RGB writes, and a monitor checks every write the DUT makes against that queue.
module tb_yuv_csc_upsampler;

    localparam int TW = 16;
    localparam int TH = 3;
    localparam int YB = 0;
    localparam int UB = 100;
    localparam int VB = 200;
    localparam int RB = 300;
    localparam int NWORDS = 3 * TW * TH / 2;
    localparam int FRAME_BOUND = TH * (4 * TW + 40);

    logic        Clock = 1'b0;
    logic        Resetn, start, mode_444;
    logic        busy, done, SRAM_we_n;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data, SRAM_read_data;

    always #5 Clock = ~Clock;

    yuv_csc_upsampler #(
        .WIDTH(TW), .HEIGHT(TH), .Y_BASE(YB), .U_BASE(UB), .V_BASE(VB), .RGB_BASE(RB)
    ) dut (
        .Clock(Clock), .Resetn(Resetn), .start(start), .mode_444(mode_444),
        .busy(busy), .done(done), .SRAM_address(SRAM_address),
        .SRAM_write_data(SRAM_write_data), .SRAM_we_n(SRAM_we_n),
        .SRAM_read_data(SRAM_read_data)
    );

    // Read-only SRAM image with a 2-cycle read pipeline; DUT writes go to the monitor.
    logic [15:0] mem [0:1023];
    logic [17:0] a1, a2;
    always @(posedge Clock) begin
        a1 <= SRAM_address;
        a2 <= a1;
    end
    assign SRAM_read_data = mem[a2[9:0]];

    typedef struct {
        logic [17:0] a;
        logic [15:0] d;
    } exp_t;
    exp_t exp_q[$];

    int n_pass = 0;
    int n_total = 0;
    int n_writes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    endtask

    always @(negedge Clock) begin
        if (Resetn === 1'b1 && SRAM_we_n === 1'b0) begin
            exp_t e;
            n_writes++;
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", SRAM_address, SRAM_write_data);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(SRAM_address), 32'(e.a));
                chk("wr_data", 32'(SRAM_write_data), 32'(e.d));
            end
        end
    end

    function automatic int smp(input int base, input int idx);
        logic [15:0] w;
        w = mem[base + idx / 2];
        return (idx % 2 == 0) ? int'(w[15:8]) : int'(w[7:0]);
    endfunction

    function automatic int clip8(input int x);
        return (x < 0) ? 0 : ((x > 255) ? 255 : x);
    endfunction

    function automatic int interp(input int base, input int j);
        int coef[6];
        int acc, k;
        coef = '{21, -52, 159, 159, -52, 21};
        acc = 128;
        for (int d = 0; d < 6; d++) begin
            k = j - 2 + d;
            if (k < 0) k = 0;
            if (k > TW / 2 - 1) k = TW / 2 - 1;
            acc += coef[d] * smp(base, k);
        end
        return clip8(acc >>> 8);
    endfunction

    task automatic build_expected(input bit m444);
        logic [7:0] rr[TW], gg[TW], bb[TW];
        int yv, uv, vv, y, u, v, idx;
        exp_t e;
        idx = 0;
        for (int r = 0; r < TH; r++) begin
            for (int p = 0; p < TW; p++) begin
                yv = smp(YB + r * (TW / 2), p);
                if (m444) begin
                    uv = smp(UB + r * (TW / 2), p);
                    vv = smp(VB + r * (TW / 2), p);
                end else if (p % 2 == 0) begin
                    uv = smp(UB + r * (TW / 4), p / 2);
                    vv = smp(VB + r * (TW / 4), p / 2);
                end else begin
                    uv = interp(UB + r * (TW / 4), p / 2);
                    vv = interp(VB + r * (TW / 4), p / 2);
                end
                y = yv - 16;
                u = uv - 128;
                v = vv - 128;
                rr[p] = 8'(clip8((76284 * y + 104595 * v) >>> 16));
                gg[p] = 8'(clip8((76284 * y - 25624 * u - 53281 * v) >>> 16));
                bb[p] = 8'(clip8((76284 * y + 132251 * u) >>> 16));
            end
            for (int k = 0; k < TW / 2; k++) begin
                e.a = 18'(RB + idx);     e.d = {rr[2*k], gg[2*k]};     exp_q.push_back(e); idx++;
                e.a = 18'(RB + idx);     e.d = {bb[2*k], rr[2*k+1]};   exp_q.push_back(e); idx++;
                e.a = 18'(RB + idx);     e.d = {gg[2*k+1], bb[2*k+1]}; exp_q.push_back(e); idx++;
            end
        end
    endtask

    task automatic fill(input bit rnd, input logic [7:0] yc, input logic [7:0] uc, input logic [7:0] vc);
        for (int i = 0; i < (TW / 2) * TH; i++) begin
            mem[YB + i] = rnd ? 16'($urandom) : {yc, yc};
            mem[UB + i] = rnd ? 16'($urandom) : {uc, uc};
            mem[VB + i] = rnd ? 16'($urandom) : {vc, vc};
        end
    endtask

    task automatic pulse_start(input bit m444);
        @(negedge Clock);
        start = 1'b1;
        mode_444 = m444;
        @(negedge Clock);
        start = 1'b0;
        mode_444 = ~m444;
    endtask

    task automatic run_frame(input bit m444, input bit poke);
        int cyc, busy_low;
        build_expected(m444);
        n_writes = 0;
        pulse_start(m444);
        cyc = 0;
        busy_low = 0;
        while (done !== 1'b1 && cyc < FRAME_BOUND) begin
            if (busy !== 1'b1) busy_low++;
            start = (poke && cyc == 40);
            @(negedge Clock);
            cyc++;
        end
        start = 1'b0;
        chk("done_seen", 32'(done), 32'd1);
        chk("busy_low_at_done", 32'(busy), 32'd0);
        chk("busy_gaps_in_frame", 32'(busy_low), 32'd0);
        @(negedge Clock);
        chk("done_single_cycle", 32'(done), 32'd0);
        chk("write_count", 32'(n_writes), 32'(NWORDS));
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int w;
        Resetn = 1'b0;
        start = 1'b0;
        mode_444 = 1'b0;
        fill(1'b1, 8'd0, 8'd0, 8'd0);
        #12;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_we_n", 32'(SRAM_we_n), 32'd1);
        chk("reset_addr", 32'(SRAM_address), 32'd0);
        chk("reset_wdata", 32'(SRAM_write_data), 32'd0);
        @(negedge Clock);
        Resetn = 1'b1;

        fill(1'b0, 8'd128, 8'd128, 8'd128);   run_frame(1'b0, 1'b0);
        fill(1'b0, 8'd0,   8'd128, 8'd128);   run_frame(1'b0, 1'b0);
        fill(1'b0, 8'd255, 8'd128, 8'd128);   run_frame(1'b0, 1'b0);

        // U[k] = 8k ramp per row exercises the FIR and both clamped edges.
        fill(1'b0, 8'd16, 8'd128, 8'd128);
        for (int r = 0; r < TH; r++)
            for (int k = 0; k < TW / 4; k++)
                mem[UB + r * (TW / 4) + k] = {8'(16 * k), 8'(16 * k + 8)};
        run_frame(1'b0, 1'b0);

        fill(1'b0, 8'd128, 8'd128, 8'd128);   run_frame(1'b1, 1'b0);
        fill(1'b1, 8'd0, 8'd0, 8'd0);         run_frame(1'b0, 1'b0);
        fill(1'b1, 8'd0, 8'd0, 8'd0);         run_frame(1'b0, 1'b1);
        fill(1'b1, 8'd0, 8'd0, 8'd0);         run_frame(1'b1, 1'b0);
        fill(1'b1, 8'd0, 8'd0, 8'd0);         run_frame(1'b1, 1'b1);

        // Reset during a write cycle mid-frame, then a clean frame.
        fill(1'b1, 8'd0, 8'd0, 8'd0);
        build_expected(1'b0);
        pulse_start(1'b0);
        repeat (100) @(negedge Clock);
        w = 0;
        while (SRAM_we_n !== 1'b0 && w < 20) begin
            @(negedge Clock);
            w++;
        end
        chk("write_before_reset", 32'(SRAM_we_n), 32'd0);
        Resetn = 1'b0;
        #1;
        chk("midreset_we_n", 32'(SRAM_we_n), 32'd1);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_addr", 32'(SRAM_address), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge Clock);
        Resetn = 1'b1;
        repeat (6) @(negedge Clock);
        chk("idle_after_reset", 32'(busy), 32'd0);
        run_frame(1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
